// File: rtl/sram_alloc_scheduler_pkg.sv
// Shared sizing constants and index types for the SRAM allocation scheduler.
package sram_alloc_scheduler_pkg;

   localparam int unsigned PORT_NUM   = 16;
   localparam int unsigned SRAM_NUM   = 32;
   localparam int unsigned SRAM_IDX_W = 5;
   localparam int unsigned PORT_IDX_W = 4;
   localparam int unsigned STRIDE     = SRAM_NUM / PORT_NUM;
   localparam int unsigned STATS_W    = 16;

   typedef logic [SRAM_IDX_W-1:0] sram_idx_t;
   typedef logic [PORT_IDX_W-1:0] port_idx_t;

endpackage : sram_alloc_scheduler_pkg

// File: rtl/sram_alloc_scheduler_rr_arbiter_16.sv
// Round-robin arbiter over 16 requesters: the first set request found when
// scanning upward from start_i (wrapping) receives a one-hot grant.
//   req_i   : request vector, one bit per port
//   start_i : port index where the search begins
//   gnt_o   : one-hot grant (all zero when there is no request)
module rr_arbiter_16
   import sram_alloc_scheduler_pkg::*;
(
   input  logic [PORT_NUM-1:0] req_i,
   input  port_idx_t           start_i,
   output logic [PORT_NUM-1:0] gnt_o
);

   logic      found;
   port_idx_t idx;

   // Rotating priority search; the 4-bit index wraps naturally.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
         idx = start_i + port_idx_t'(i);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule : rr_arbiter_16

// File: rtl/sram_alloc_scheduler.sv
// Shares 32 SRAMs among 16 write ports during SRAM matching: rotates a
// collision-free candidate SRAM per port, masks SRAMs owned by other ports,
// arbitrates claims and keeps the ownership table until ports release.
//   clk, rst_n        : clock, asynchronous active-low reset
//   scan_enable_i     : advance the scan rotation by one
//   matching_sram_o   : per-port candidate SRAM, port p at [5p+4:5p] (comb)
//   accessible_o      : candidate is free or owned by that port (comb)
//   claim_req_i       : per-port claim pulse
//   claim_sram_i      : per-port SRAM being claimed
//   claim_grant_o     : grant pulse, one cycle after the claim
//   claim_nack_o      : reject pulse, one cycle after the claim
//   release_i         : per-port release pulse of the owned SRAM
//   own_valid_o       : port currently owns an SRAM
//   own_sram_o        : SRAM owned by each port
// Optional CLAIM_STATS_EN adds stats_clr_i (sync clear) and nack_count_o
// (saturating count of nack pulses).
module sram_alloc_scheduler
   import sram_alloc_scheduler_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           scan_enable_i,
   output logic [PORT_NUM*SRAM_IDX_W-1:0] matching_sram_o,
   output logic [PORT_NUM-1:0]            accessible_o,
   input  logic [PORT_NUM-1:0]            claim_req_i,
   input  logic [PORT_NUM*SRAM_IDX_W-1:0] claim_sram_i,
   output logic [PORT_NUM-1:0]            claim_grant_o,
   output logic [PORT_NUM-1:0]            claim_nack_o,
   input  logic [PORT_NUM-1:0]            release_i,
   output logic [PORT_NUM-1:0]            own_valid_o,
   output logic [PORT_NUM*SRAM_IDX_W-1:0] own_sram_o
`ifdef CLAIM_STATS_EN
   ,
   input  logic                           stats_clr_i,
   output logic [STATS_W-1:0]             nack_count_o
`endif
);

   // Registered state
   sram_idx_t             scan_base_q, scan_base_d;
   port_idx_t             rr_ptr_q, rr_ptr_d;
   logic [SRAM_NUM-1:0]   sram_owned_q, sram_owned_d;
   port_idx_t             sram_owner_q [SRAM_NUM];
   port_idx_t             sram_owner_d [SRAM_NUM];
   logic [PORT_NUM-1:0]   grant_q, grant_d;
   logic [PORT_NUM-1:0]   nack_q, nack_d;
   logic [PORT_NUM-1:0]   own_valid_q, own_valid_d;
   sram_idx_t             own_sram_q [PORT_NUM];
   sram_idx_t             own_sram_d [PORT_NUM];

   // Arbitration intermediates
   sram_idx_t             cand [PORT_NUM];
   sram_idx_t             csram [PORT_NUM];
   logic [PORT_NUM-1:0]   rel_eff;
   logic [PORT_NUM-1:0]   still_owns;
   logic [SRAM_NUM-1:0]   owned_post;
   logic [PORT_NUM-1:0]   eligible;
   logic [SRAM_NUM-1:0]   contested;
   logic [PORT_NUM-1:0]   req_mat [SRAM_NUM];
   logic [PORT_NUM-1:0]   gnt_mat [SRAM_NUM];

   // Candidate per port: base plus a fixed stride keeps all ports distinct.
   always_comb begin
      matching_sram_o = '0;
      accessible_o    = '0;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
         cand[p] = scan_base_q + sram_idx_t'(p * STRIDE);
         matching_sram_o[p*SRAM_IDX_W +: SRAM_IDX_W] = cand[p];
         accessible_o[p] = ~sram_owned_q[cand[p]] |
                           (sram_owner_q[cand[p]] == port_idx_t'(p));
      end
   end

   // Releases apply first (non-owners ignored); then decide which claims compete.
   always_comb begin
      rel_eff    = release_i & own_valid_q;
      still_owns = own_valid_q & ~rel_eff;
      owned_post = sram_owned_q;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
         if (rel_eff[p]) owned_post[own_sram_q[p]] = 1'b0;
      end
      eligible = '0;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
         csram[p]    = claim_sram_i[p*SRAM_IDX_W +: SRAM_IDX_W];
         eligible[p] = claim_req_i[p] & ~still_owns[p] & ~owned_post[csram[p]];
      end
   end

   // Per-SRAM request matrix; two or more requesters make the SRAM contested.
   always_comb begin
      contested = '0;
      for (int unsigned s = 0; s < SRAM_NUM; s++) begin
         req_mat[s] = '0;
         for (int unsigned p = 0; p < PORT_NUM; p++) begin
            req_mat[s][p] = eligible[p] & (csram[p] == sram_idx_t'(s));
         end
         contested[s] = |(req_mat[s] & (req_mat[s] - PORT_NUM'(1)));
      end
   end

   for (genvar s = 0; s < SRAM_NUM; s++) begin : g_arb
      rr_arbiter_16 u_arb (
         .req_i   (req_mat[s]),
         .start_i (rr_ptr_q),
         .gnt_o   (gnt_mat[s])
      );
   end

   // Next-state table update; when several SRAMs are contested in one cycle
   // the winner on the highest-index SRAM sets the new round-robin pointer.
   always_comb begin
      scan_base_d  = scan_enable_i ? scan_base_q + sram_idx_t'(1) : scan_base_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = '0;
      sram_owned_d = owned_post;
      sram_owner_d = sram_owner_q;
      own_valid_d  = still_owns;
      own_sram_d   = own_sram_q;
      for (int unsigned s = 0; s < SRAM_NUM; s++) begin
         for (int unsigned p = 0; p < PORT_NUM; p++) begin
            if (gnt_mat[s][p]) begin
               grant_d[p]      = 1'b1;
               sram_owned_d[s] = 1'b1;
               sram_owner_d[s] = port_idx_t'(p);
               own_valid_d[p]  = 1'b1;
               own_sram_d[p]   = sram_idx_t'(s);
               if (contested[s]) rr_ptr_d = port_idx_t'(p + 1);
            end
         end
      end
      nack_d = claim_req_i & ~grant_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_base_q  <= '0;
         rr_ptr_q     <= '0;
         sram_owned_q <= '0;
         sram_owner_q <= '{default: '0};
         grant_q      <= '0;
         nack_q       <= '0;
         own_valid_q  <= '0;
         own_sram_q   <= '{default: '0};
      end else begin
         scan_base_q  <= scan_base_d;
         rr_ptr_q     <= rr_ptr_d;
         sram_owned_q <= sram_owned_d;
         sram_owner_q <= sram_owner_d;
         grant_q      <= grant_d;
         nack_q       <= nack_d;
         own_valid_q  <= own_valid_d;
         own_sram_q   <= own_sram_d;
      end
   end

   always_comb begin
      own_sram_o = '0;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
         own_sram_o[p*SRAM_IDX_W +: SRAM_IDX_W] = own_sram_q[p];
      end
   end

   assign claim_grant_o = grant_q;
   assign claim_nack_o  = nack_q;
   assign own_valid_o   = own_valid_q;

`ifdef CLAIM_STATS_EN
   localparam int unsigned SUM_W = STATS_W + 1;

   logic [STATS_W-1:0] nack_count_q;
   logic [SUM_W-1:0]   nack_sum;

   // Extra carry bit detects saturation.
   always_comb begin
      nack_sum = {1'b0, nack_count_q} + SUM_W'($countones(nack_d));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nack_count_q <= '0;
      end else if (stats_clr_i) begin
         nack_count_q <= '0;
      end else if (nack_sum[STATS_W]) begin
         nack_count_q <= '1;
      end else begin
         nack_count_q <= nack_sum[STATS_W-1:0];
      end
   end

   assign nack_count_o = nack_count_q;
`endif

endmodule : sram_alloc_scheduler

// File: tb/tb_sram_alloc_scheduler.sv
// Self-checking bench for sram_alloc_scheduler: directed scenarios plus
// randomized traffic compared against an ownership-table reference model.
module tb_sram_alloc_scheduler;
   import sram_alloc_scheduler_pkg::*;

   localparam int NP = 16;
   localparam int NS = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_enable;
   logic [79:0] matching_sram;
   logic [15:0] accessible;
   logic [15:0] claim_req;
   logic [79:0] claim_sram;
   logic [15:0] claim_grant;
   logic [15:0] claim_nack;
   logic [15:0] release_v;
   logic [15:0] own_valid;
   logic [79:0] own_sram;
`ifdef CLAIM_STATS_EN
   logic        stats_clr;
   logic [15:0] nack_count;
`endif

   sram_alloc_scheduler dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .scan_enable_i   (scan_enable),
      .matching_sram_o (matching_sram),
      .accessible_o    (accessible),
      .claim_req_i     (claim_req),
      .claim_sram_i    (claim_sram),
      .claim_grant_o   (claim_grant),
      .claim_nack_o    (claim_nack),
      .release_i       (release_v),
      .own_valid_o     (own_valid),
      .own_sram_o      (own_sram)
`ifdef CLAIM_STATS_EN
      ,
      .stats_clr_i     (stats_clr),
      .nack_count_o    (nack_count)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Stimulus for the next cycle
   logic [15:0] st_req, st_rel;
   int          st_csram [NP];
   logic        st_se, st_clr;

   // Reference model: who owns what, plus scan/rr/statistics state
   int          m_owner [NS];   // -1 = free
   int          m_own [NP];     // -1 = owns nothing
   int          m_rr, m_base, m_ncnt;
   logic [15:0] m_gnt, m_nack;

   task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [4:0] slot(input logic [79:0] v, input int p);
      return v[p*5 +: 5];
   endfunction

   task automatic m_reset();
      for (int s = 0; s < NS; s++) m_owner[s] = -1;
      for (int p = 0; p < NP; p++) m_own[p] = -1;
      m_rr = 0; m_base = 0; m_ncnt = 0; m_gnt = '0; m_nack = '0;
   endtask

   task automatic idle();
      st_req = '0; st_rel = '0; st_se = 1'b0; st_clr = 1'b0;
      for (int p = 0; p < NP; p++) st_csram[p] = 0;
   endtask

   task automatic drive();
      claim_req   = st_req;
      release_v   = st_rel;
      scan_enable = st_se;
      for (int p = 0; p < NP; p++) claim_sram[p*5 +: 5] = 5'(st_csram[p]);
`ifdef CLAIM_STATS_EN
      stats_clr = st_clr;
`endif
   endtask

   // One clock of the allocation rules, applied to the model state.
   task automatic model_step();
      int new_rr;
      new_rr = m_rr;
      for (int p = 0; p < NP; p++) begin
         if (st_rel[p] && m_own[p] >= 0) begin
            m_owner[m_own[p]] = -1;
            m_own[p] = -1;
         end
      end
      m_gnt = '0;
      for (int s = 0; s < NS; s++) begin
         int cnt, win;
         cnt = 0; win = -1;
         if (m_owner[s] < 0) begin
            for (int k = 0; k < NP; k++) begin
               int p;
               p = (m_rr + k) % NP;
               if (st_req[p] && st_csram[p] == s && m_own[p] < 0) begin
                  cnt++;
                  if (win < 0) win = p;
               end
            end
         end
         if (win >= 0) begin
            m_owner[s] = win;
            m_own[win] = s;
            m_gnt[win] = 1'b1;
            if (cnt > 1) new_rr = (win + 1) % NP;
         end
      end
      m_rr   = new_rr;
      m_nack = st_req & ~m_gnt;
      m_base = (m_base + (st_se ? 1 : 0)) % NS;
      if (st_clr) m_ncnt = 0;
      else m_ncnt = (m_ncnt + $countones(m_nack) > 65535) ? 65535 : m_ncnt + $countones(m_nack);
   endtask

   task automatic compare_all();
      logic [79:0] em, eo, mask;
      logic [15:0] ea, ev;
      em = '0; eo = '0; mask = '0; ea = '0; ev = '0;
      for (int p = 0; p < NP; p++) begin
         int s;
         s = (m_base + 2 * p) % NS;
         em[p*5 +: 5] = 5'(s);
         ea[p] = (m_owner[s] < 0) || (m_owner[s] == p);
         if (m_own[p] >= 0) begin
            ev[p] = 1'b1;
            eo[p*5 +: 5] = 5'(m_own[p]);
            mask[p*5 +: 5] = 5'h1F;
         end
      end
      check("matching_sram", matching_sram, em);
      check("accessible", 80'(accessible), 80'(ea));
      check("claim_grant", 80'(claim_grant), 80'(m_gnt));
      check("claim_nack", 80'(claim_nack), 80'(m_nack));
      check("own_valid", 80'(own_valid), 80'(ev));
      check("own_sram", own_sram & mask, eo);
`ifdef CLAIM_STATS_EN
      check("nack_count", 80'(nack_count), 80'(m_ncnt));
`endif
   endtask

   task automatic step();
      @(negedge clk);
      drive();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      idle();
      drive();
      m_reset();
      #12;
      compare_all();
      check("rst_match15", 80'(slot(matching_sram, 15)), 80'(30));
      check("rst_grant", 80'(claim_grant), 80'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Scan rotation for three cycles
      st_se = 1'b1;
      repeat (3) step();
      check("scan_match0", 80'(slot(matching_sram, 0)), 80'(3));
      check("scan_match15", 80'(slot(matching_sram, 15)), 80'(1));
      check("scan_access", 80'(accessible), 80'(16'hFFFF));
      idle();

      // Ports 4 and 8 contest SRAM 20 from rr_ptr 0: port 4 wins, pointer moves to 5
      st_req[4] = 1'b1; st_csram[4] = 20;
      st_req[8] = 1'b1; st_csram[8] = 20;
      step();
      check("contest0_grant", 80'(claim_grant), 80'(16'h0010));
      check("contest0_nack", 80'(claim_nack), 80'(16'h0100));
      idle();

      // Port 4 atomically switches to SRAM 7; port 2 scans SRAM 7
      st_rel[4] = 1'b1; st_req[4] = 1'b1; st_csram[4] = 7;
      step();
      check("claim7_grant", 80'(claim_grant), 80'(16'h0010));
      check("claim7_own", 80'(slot(own_sram, 4)), 80'(7));
      check("claim7_acc2", 80'(accessible[2]), 80'(0));
      check("claim7_acc4", 80'(accessible[4]), 80'(1));
      idle();

      // Ports 2 and 9 contest SRAM 10 with rr_ptr 5: port 9 wins
      st_req[2] = 1'b1; st_csram[2] = 10;
      st_req[9] = 1'b1; st_csram[9] = 10;
      step();
      check("contest1_grant", 80'(claim_grant), 80'(16'h0200));
      check("contest1_nack", 80'(claim_nack), 80'(16'h0004));
      idle();

      // Ports 6 and 10 on SRAM 25: winner 10 only if the pointer moved to 10
      st_req[6] = 1'b1; st_csram[6] = 25;
      st_req[10] = 1'b1; st_csram[10] = 25;
      step();
      check("contest2_grant", 80'(claim_grant), 80'(16'h0400));
      check("contest2_nack", 80'(claim_nack), 80'(16'h0040));
      idle();

      // Owner claiming a second SRAM without release is rejected
      st_req[4] = 1'b1; st_csram[4] = 12;
      step();
      check("reclaim_nack", 80'(claim_nack), 80'(16'h0010));
      check("reclaim_own", 80'(slot(own_sram, 4)), 80'(7));
      idle();

      // Same with release: switch succeeds and SRAM 7 becomes free
      st_rel[4] = 1'b1; st_req[4] = 1'b1; st_csram[4] = 12;
      step();
      check("switch_grant", 80'(claim_grant), 80'(16'h0010));
      check("switch_own", 80'(slot(own_sram, 4)), 80'(12));
      check("switch_acc2", 80'(accessible[2]), 80'(1));
      idle();

      // Randomized traffic with deliberate contention on a few SRAMs
      for (int n = 0; n < 1500; n++) begin
         for (int p = 0; p < NP; p++) begin
            st_req[p] = ($urandom_range(0, 3) == 0);
            st_rel[p] = ($urandom_range(0, 7) == 0);
            st_csram[p] = ($urandom_range(0, 1) == 0) ? (m_base + 2 * p) % NS
                                                      : int'($urandom_range(0, 7));
         end
         st_se = 1'($urandom_range(0, 1));
`ifdef CLAIM_STATS_EN
         st_clr = ($urandom_range(0, 63) == 0);
`endif
         step();
      end
      idle();

      // Reset asserted while a claim is pending: no grant, table cleared at once
      @(negedge clk);
      st_req = 16'hFFFF;
      for (int p = 0; p < NP; p++) st_csram[p] = p;
      drive();
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      idle();
      compare_all();
      check("midrst_access", 80'(accessible), 80'(16'hFFFF));
      @(posedge clk);
      #1;
      check("midrst_grant", 80'(claim_grant), 80'(0));
      check("midrst_valid", 80'(own_valid), 80'(0));
      @(negedge clk);
      drive();
      rst_n = 1'b1;
      step();

`ifdef CLAIM_STATS_EN
      // Three losers on one SRAM add three
      st_req = 16'h000F;
      for (int p = 0; p < 4; p++) st_csram[p] = 5;
      step();
      check("stats_3", 80'(nack_count), 80'(3));
      idle();
      // Every port takes its own SRAM while clearing the counter
      st_clr = 1'b1; st_req = 16'hFFFF;
      for (int p = 0; p < NP; p++) st_csram[p] = p + 8;
      st_rel = 16'hFFFF;
      step();
      check("stats_clr0", 80'(nack_count), 80'(0));
      st_clr = 1'b0; st_rel = '0;
      repeat (4095) step();
      st_req = 16'h3FFF;
      step();
      check("stats_fffe", 80'(nack_count), 80'(16'hFFFE));
      st_req = 16'h0003;
      step();
      check("stats_sat", 80'(nack_count), 80'(16'hFFFF));
      st_req = 16'hFFFF;
      step();
      check("stats_hold", 80'(nack_count), 80'(16'hFFFF));
      st_req = 16'h00FF; st_clr = 1'b1;
      step();
      check("stats_clr", 80'(nack_count), 80'(0));
      idle();
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sram_alloc_scheduler

// File: doc/sram_alloc_scheduler.md
Name: sram_alloc_scheduler

Overview:
- Shares the 32 SRAMs among the 16 write ports during SRAM matching.
- Each cycle it feeds every port's SRAM matcher a distinct candidate SRAM index, with a rotating, collision-free scan offset.
- It masks SRAMs owned by other ports as inaccessible.
- It arbitrates claims on a matched SRAM and keeps the ownership table until each port releases its SRAM.

Parameters:
- PORT_NUM, 16, number of write ports; must divide SRAM_NUM.
- SRAM_NUM, 32, number of SRAMs; SRAM index width is 5.
- STRIDE, SRAM_NUM/PORT_NUM (2), per-port scan offset; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_enable  in  1  advances the scan rotation.
- matching_sram  out  PORT_NUM*5  per-port candidate SRAM index; port p occupies bits [5p+4:5p].
- accessible  out  PORT_NUM  candidate of port p is free or already owned by p.
- claim_req  in  PORT_NUM  one-cycle claim pulse; driven from the port matcher's match_suc.
- claim_sram  in  PORT_NUM*5  SRAM being claimed; driven from matching_best_sram.
- claim_grant  out  PORT_NUM  one-cycle grant pulse.
- claim_nack  out  PORT_NUM  one-cycle reject pulse.
- release  in  PORT_NUM  one-cycle pulse; port gives up its SRAM.
- own_valid  out  PORT_NUM  port currently owns an SRAM.
- own_sram  out  PORT_NUM*5  SRAM owned by the port; valid only when own_valid is 1.

Behaviour:
- Reset (asynchronous, rst_n=0) clears:
  - scan_base=0 and rr_ptr=0;
  - ownership table: all sram_owned=0;
  - claim_grant=0, claim_nack=0, own_valid=0, own_sram=0.
  - Consequence: matching_sram[p] = 2p and accessible = all 1.
- Scan:
  - matching_sram[p] = (scan_base + p*STRIDE) mod SRAM_NUM, computed combinationally from the scan_base register.
  - scan_base increments by 1 per cycle while scan_enable=1 and wraps 31→0; otherwise it holds.
  - Per cycle, all ports see distinct SRAMs.
- accessible[p] = ~sram_owned[s] | (sram_owner[s]==p), where s = matching_sram[p]. Combinational from the table.
- Claim arbitration (registered, 1-cycle latency):
  - Claims sampled at cycle t produce grant/nack pulses at t+1. The table updates at the same edge, so accessible reflects it at t+1.
  - Ordering of each request class within a cycle:
    1. Releases are applied first. A release from a non-owner is ignored.
    2. A claim by a port that still owns an SRAM after step 1 → nack.
    3. A claim on an SRAM owned by another port → nack.
    4. Several claims on the same free SRAM → round-robin winner gets the grant; search starts at rr_ptr, increasing port index, wrapping. All losers → nack.
    5. Claims on different free SRAMs → all granted in the same cycle.
  - Every claim_req bit yields exactly one of grant/nack at t+1, never both.
  - rr_ptr moves to (last granted contested winner + 1) mod PORT_NUM. It is unchanged when the cycle has no contested grant.
  - Release and claim by the same port on the same cycle: the release frees the old SRAM, then the claim is evaluated. This allows an atomic switch.
- Grant at t+1:
  - sets sram_owned[s]=1 and sram_owner[s]=p;
  - sets own_valid[p]=1 and own_sram[p]=s.
- Release at t+1: clears sram_owned for that SRAM and clears own_valid[p].
- scan_enable does not gate claims or releases.

Optional Feature:
- Macro: CLAIM_STATS_EN.
- When defined:
  - adds output nack_count (16 bits): total claim_nack pulses, saturating at 0xFFFF;
  - adds input stats_clr (1 bit): synchronous clear, which has priority over counting;
  - nack_count resets to 0;
  - multiple nacks in one cycle add their popcount, saturating.
- When undefined: neither port nor the counter exists. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - PORT_NUM, SRAM_NUM, SRAM_IDX_W=5, PORT_IDX_W=4;
  - typedef sram_idx_t, typedef port_idx_t.
- One natural sub-module: rr_arbiter_16. It takes a request vector plus a start pointer and returns a one-hot grant. It is instantiated once per SRAM, or time-shared through a per-SRAM request matrix built in the parent.

Test Plan:
- Reset, scan_enable=1 for 3 cycles → matching_sram[0]=3, matching_sram[15]=1, accessible=0xFFFF.
- Port 4 claims SRAM 7 at t → grant[4] at t+1, own_sram[4]=7. Any port scanning SRAM 7 other than 4 sees accessible=0; port 4 sees 1.
- Ports 2 and 9 claim SRAM 10 on the same cycle with rr_ptr=5 → grant[9], nack[2], rr_ptr=10.
- Port 4, owning SRAM 7, claims SRAM 12 without release → nack[4], own_sram[4] stays 7. With release in the same cycle → grant[4], SRAM 7 freed, own_sram[4]=12.
- Assert rst_n low mid-claim (claim_req on a cycle where rst_n falls) → no grant pulse, all ownership cleared immediately, accessible=0xFFFF.
- With CLAIM_STATS_EN: 3 simultaneous losers → nack_count +3. Preload near saturation (0xFFFE) plus 2 nacks → 0xFFFF. stats_clr → 0.
